// File: rtl/lram_burst_ctrl.sv
// Burst controller for a single LRAM port in registered-output mode (2-cycle read latency).
// Accepts write/read burst commands and streams data through valid/ready ports.
module lram_burst_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_ben_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    lram_clk_en_o,
  output logic                    lram_rdout_clken_o,
  output logic                    lram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   lram_addr_o,
  output logic [DATA_WIDTH-1:0]   lram_wr_data_o,
  output logic [DATA_WIDTH/8-1:0] lram_ben_o,
  input  logic [DATA_WIDTH-1:0]   lram_rd_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              state_o
);
  // Handshakes: a transfer happens on a cycle where valid and ready are both 1
  // at the rising clock edge; valid must not depend on ready.

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DRAIN = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, iss_addr;
  logic [LEN_WIDTH-1:0]    len_q, iss_len;
  logic [DATA_WIDTH-1:0]   fifo_mem [0:3];
  logic [1:0]              rd_ptr, wr_ptr, inflight;
  logic [2:0]              fifo_cnt, cnt_nxt;
  logic [2:0]              rd_pipe;
  logic [3:0]              occ;
  logic                    done_q, cmd_hs, wr_hs, wr_last, push, pop, room, issue, rd_last_pop;

  assign cmd_ready_o = (state == IDLE) && !rst_i;
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign wr_ready_o  = (state == WRITE);
  assign wr_hs       = wr_valid_i && wr_ready_o;
  assign wr_last     = wr_hs && (len_q == LEN_WIDTH'(1));
  assign rd_valid_o  = (fifo_cnt != 3'd0);
  assign rd_data_o   = rd_valid_o ? fifo_mem[rd_ptr] : '0;
  assign pop         = rd_valid_o && rd_ready_i;
  // rd_pipe[2] marks the cycle in which issued read data sits on lram_rd_data_i.
  assign push        = rd_pipe[2];
  assign cnt_nxt     = fifo_cnt + 3'(push) - 3'(pop);
  assign occ         = {1'b0, fifo_cnt} + {2'b00, inflight};
  assign room        = (occ < 4'd4);
  assign rd_last_pop = (state == DRAIN) && (inflight == 2'd0) && (fifo_cnt == 3'd1) && pop;
  assign done_o      = done_q || rd_last_pop;
  assign busy_o      = (state != IDLE);
  assign state_o     = state;

  // The first read of a burst issues on the command handshake itself.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    iss_addr  = addr_q;
    iss_len   = len_q;
    case (state)
      IDLE: begin
        if (cmd_hs && (cmd_len_i != '0)) begin
          if (cmd_write_i) begin
            state_nxt = WRITE;
          end else begin
            issue     = 1'b1;
            iss_addr  = cmd_addr_i;
            iss_len   = cmd_len_i;
            state_nxt = (cmd_len_i == LEN_WIDTH'(1)) ? DRAIN : READ;
          end
        end
      end
      WRITE: if (wr_last) state_nxt = IDLE;
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (len_q == LEN_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: if ((inflight == 2'd0) && (cnt_nxt == 3'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lram_clk_en_o      <= 1'b0;
      lram_rdout_clken_o <= 1'b0;
      lram_wr_en_o       <= 1'b0;
      lram_addr_o        <= '0;
      lram_wr_data_o     <= '0;
      lram_ben_o         <= '0;
      addr_q             <= '0;
      len_q              <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      fifo_cnt           <= '0;
      inflight           <= '0;
      rd_pipe            <= '0;
      done_q             <= 1'b0;
    end else begin
      lram_clk_en_o      <= issue || wr_hs;
      lram_wr_en_o       <= wr_hs;
      lram_rdout_clken_o <= (state_nxt != IDLE);
      if (wr_hs) begin
        lram_addr_o    <= addr_q;
        lram_wr_data_o <= wr_data_i;
        lram_ben_o     <= wr_ben_i;
      end else if (issue) begin
        lram_addr_o <= iss_addr;
      end
      if (issue || wr_hs) begin
        addr_q <= iss_addr + ADDR_WIDTH'(1);
        len_q  <= iss_len - LEN_WIDTH'(1);
      end else if (cmd_hs) begin
        addr_q <= cmd_addr_i;
        len_q  <= cmd_len_i;
      end
      rd_pipe  <= {rd_pipe[1:0], issue};
      inflight <= inflight + 2'(issue) - 2'(push);
      fifo_cnt <= cnt_nxt;
      rd_ptr   <= rd_ptr + 2'(pop);
      wr_ptr   <= wr_ptr + 2'(push);
      done_q   <= (cmd_hs && (cmd_len_i == '0)) || wr_last;
    end
  end

  // Storage needs no reset: entries are only visible through fifo_cnt.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= lram_rd_data_i;
  end

endmodule

// File: tb/tb_lram_burst_ctrl.sv
// Bench for lram_burst_ctrl: behavioural LRAM, shadow memory reference and
// expected queues for LRAM writes, read addresses and returned read data.
module tb_lram_burst_ctrl;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LW = 14;
  localparam int BW = DW / 8;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_ben = '0;
  logic          rd_valid, rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          lram_clk_en, lram_rdout_clken, lram_wr_en;
  logic [AW-1:0] lram_addr;
  logic [DW-1:0] lram_wr_data;
  logic [BW-1:0] lram_ben;
  logic [DW-1:0] lram_rd_data = '0;
  logic          busy, done;
  logic [1:0]    dut_state;

  lram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_ben_i(wr_ben),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .lram_clk_en_o(lram_clk_en), .lram_rdout_clken_o(lram_rdout_clken),
    .lram_wr_en_o(lram_wr_en), .lram_addr_o(lram_addr), .lram_wr_data_o(lram_wr_data),
    .lram_ben_o(lram_ben), .lram_rd_data_i(lram_rd_data),
    .busy_o(busy), .done_o(done), .state_o(dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // LRAM model: read issued in T -> stage register -> output register valid in T+2
  bit [DW-1:0] lram_mem [0:AMASK];
  bit [DW-1:0] lram_stage;
  always @(posedge clk) begin
    if (lram_clk_en) begin
      if (lram_wr_en) begin
        for (int b = 0; b < BW; b++)
          if (!lram_ben[b]) lram_mem[lram_addr][8*b +: 8] <= lram_wr_data[8*b +: 8];
      end else begin
        lram_stage <= lram_mem[lram_addr];
      end
    end
    if (lram_rdout_clken) lram_rd_data <= lram_stage;
  end

  // read back-pressure: 0 = hold low, 1 = always ready, 2 = random
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  bit [DW-1:0]   shadow [0:AMASK];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [BW-1:0] exp_wb[$];
  logic          exp_wl[$];
  logic [AW-1:0] exp_ra[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wbeat_d[$];
  logic [BW-1:0] wbeat_b[$];
  int rd_left   = 0;
  int n_done    = 0;
  int exp_done  = 0;
  int n_clk_en  = 0;
  int n_rd_iss  = 0;
  int n_rd_seen = 0;
  logic [DW-1:0] last_pop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("rdout_clken", lram_rdout_clken, busy);
      if (lram_clk_en) n_clk_en++;
      if (lram_clk_en && lram_wr_en) begin
        if (exp_wa.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", lram_addr, exp_wa.pop_front());
          check("wr_data", lram_wr_data, exp_wd.pop_front());
          check("wr_ben", lram_ben, exp_wb.pop_front());
          check("wr_done", done, exp_wl.pop_front());
        end
      end
      if (lram_clk_en && !lram_wr_en) begin
        n_rd_iss++;
        if (exp_ra.size() == 0) check("rd_issue_unexpected", 1, 0);
        else check("rd_addr", lram_addr, exp_ra.pop_front());
      end
      if (rd_valid) n_rd_seen++;
      if (rd_valid && rd_ready) begin
        last_pop = rd_data;
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          check("rd_data", rd_data, exp_q.pop_front());
          check("rd_done", done, (rd_left == 1));
          rd_left--;
        end
      end
      if (done) n_done++;
    end
  end

  // driver tasks
  task automatic send_cmd(input bit wr, input int addr, input int len);
    bit ok = 0;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("cmd_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && exp_wa.size() == 0 && exp_ra.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // beats come from wbeat_d / wbeat_b
  task automatic write_burst(input int addr, input int len);
    logic [DW-1:0] d [$];
    logic [BW-1:0] b [$];
    for (int i = 0; i < len; i++) begin
      int a = (addr + i) & AMASK;
      d.push_back(wbeat_d.pop_front());
      b.push_back(wbeat_b.pop_front());
      exp_wa.push_back(AW'(a));
      exp_wd.push_back(d[i]);
      exp_wb.push_back(b[i]);
      exp_wl.push_back(i == len - 1);
      for (int k = 0; k < BW; k++)
        if (!b[i][k]) shadow[a][8*k +: 8] = d[i][8*k +: 8];
    end
    exp_done++;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i < len; i++) begin
      bit ok = 0;
      int gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      wr_valid = 1'b1;
      wr_data  = d[i];
      wr_ben   = b[i];
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (wr_ready) begin ok = 1; break; end
      end
      if (!ok) check("wr_timeout", 0, 1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic expect_read(input int addr, input int len);
    for (int i = 0; i < len; i++) begin
      exp_ra.push_back(AW'((addr + i) & AMASK));
      exp_q.push_back(shadow[(addr + i) & AMASK]);
    end
    rd_left = len;
    exp_done++;
  endtask

  task automatic read_burst(input int addr, input int len);
    expect_read(addr, len);
    send_cmd(1'b0, addr, len);
    wait_idle();
  endtask

  task automatic rand_write(input int addr, input int len, input bit full_ben);
    for (int i = 0; i < len; i++) begin
      wbeat_d.push_back($urandom);
      wbeat_b.push_back(full_ben ? BW'(0) : BW'($urandom_range(0, (1 << BW) - 1)));
    end
    write_burst(addr, len);
  endtask

  initial begin
    int k, snap;
    // reset values while reset is held
    #1;
    check("rst_clk_en", lram_clk_en, 0);
    check("rst_wr_en", lram_wr_en, 0);
    check("rst_rdout", lram_rdout_clken, 0);
    check("rst_addr", lram_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);
    @(posedge clk);
    #1;

    // write 0x10..0x13 then read back
    for (int i = 0; i < 4; i++) begin
      wbeat_d.push_back(DW'(32'hA0 + i));
      wbeat_b.push_back('0);
    end
    write_burst(32'h10, 4);
    read_burst(32'h10, 4);
    check("readback_last", last_pop, 32'hA3);

    // wrapping read at 0x3FFE with latency measurement
    rand_write(32'h3FFE, 4, 1'b1);
    expect_read(32'h3FFE, 4);
    send_cmd(1'b0, 32'h3FFE, 4);
    for (k = 1; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (rd_valid) break;
    end
    check("rd_latency", k, 3);
    wait_idle();

    // back-pressure: 16-word read with ready held low for 20 cycles
    rand_write(32'h0200, 16, 1'b0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    expect_read(32'h0200, 16);
    n_rd_iss = 0;
    send_cmd(1'b0, 32'h0200, 16);
    repeat (20) @(negedge clk);
    check("bp_issued", n_rd_iss, 4);
    check("bp_fifo_full_valid", rd_valid, 1);
    rdy_mode = 1;
    wait_idle();
    check("bp_all_returned", exp_q.size(), 0);

    // byte-enable merge
    wbeat_d.push_back(32'h12345678); wbeat_b.push_back(4'b0000);
    write_burst(32'h0100, 1);
    wbeat_d.push_back(32'hFFFFFFFF); wbeat_b.push_back(4'b1110);
    write_burst(32'h0100, 1);
    read_burst(32'h0100, 1);
    check("ben_merge", last_pop, 32'h123456FF);

    // zero-length command
    snap = n_clk_en;
    exp_done++;
    send_cmd(1'b0, 32'h0040, 0);
    @(negedge clk);
    check("zlen_done", done, 1);
    check("zlen_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("zlen_no_access", n_clk_en, snap);
    @(posedge clk);
    #1;

    // randomized bursts
    for (int t = 0; t < 30; t++) begin
      int a = $urandom_range(0, AMASK);
      int l = $urandom_range(1, 12);
      rdy_mode = $urandom_range(1, 2);
      if ($urandom_range(0, 1)) rand_write(a, l, 1'b0);
      else read_burst(a, l);
    end
    rdy_mode = 1;

    // reset in DRAIN with two reads in flight
    rdy_mode = 0;
    @(posedge clk);
    #1;
    exp_ra.push_back(AW'(32'h0300));
    exp_ra.push_back(AW'(32'h0301));
    send_cmd(1'b0, 32'h0300, 2);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_clk_en", lram_clk_en, 0);
    check("mid_rst_rdout", lram_rdout_clken, 0);
    check("mid_rst_addr", lram_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_data", rd_data, 0);
    exp_q.delete();
    rd_left = 0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_rd_seen = 0;
    repeat (8) @(negedge clk);
    check("post_rst_no_rd_valid", n_rd_seen, 0);
    @(posedge clk);
    #1;
    read_burst(32'h0010, 1);
    check("post_rst_read", last_pop, 32'hA0);

    check("done_count", n_done, exp_done);
    check("queues_empty", exp_q.size() + exp_wa.size() + exp_ra.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
